// File: rtl/theremin_pkg.sv
// Shared types and defaults for the antenna frequency meter.
// Holds the measurement state enum and the default gate length and count width.
package theremin_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_e;

    localparam logic [31:0] GATE_CYCLES_DEF = 32'd1_000_000;
    localparam int          CNT_W_DEF       = 24;

endpackage

// File: rtl/ant_edge_sync.sv
// Brings the asynchronous antenna comparator output into clk_100 and emits a
// one-cycle pulse per rising edge, three cycles after the pin transition.
module ant_edge_sync (
    input  logic clk_100,
    input  logic reset_n,
    input  logic ant_in,
    output logic edge_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic edge_q;

    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= ant_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    assign edge_pulse = edge_q;

endmodule

// File: rtl/ant_freq_meter.sv
// Gated rising-edge counter for the antenna oscillator: counts edges over
// GATE_CYCLES-long windows and hands each result over a valid/ready port.
//
// state      | meaning
// ST_IDLE    | stopped; waiting for enable, counters parked at zero
// ST_MEASURE | gate window running; edges accumulate until the last cycle
module ant_freq_meter
    import theremin_pkg::*;
#(
    parameter logic [31:0] GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int          CNT_W       = CNT_W_DEF
) (
    input  logic             clk_100,
    input  logic             reset_n,
    input  logic             ant_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    input  logic             freq_ready,
    output logic             no_signal,
    output logic             overflow,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [31:0]      GATE_LAST = GATE_CYCLES - 32'd1;

    logic edge_pulse;

    meter_state_e     state_q,   state_d;
    logic [31:0]      gate_q,    gate_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             sat_q,     sat_d;
    logic [CNT_W-1:0] fcount_q,  fcount_d;
    logic             valid_q,   valid_d;
    logic             nosig_q,   nosig_d;
    logic             ovfl_q,    ovfl_d;
    logic             overrun_q, overrun_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             sat_inc;
    logic             last_cycle;
    logic             load;

    ant_edge_sync u_edge_sync (
        .clk_100    (clk_100),
        .reset_n    (reset_n),
        .ant_in     (ant_in),
        .edge_pulse (edge_pulse)
    );

    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            gate_q    <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            fcount_q  <= '0;
            valid_q   <= 1'b0;
            nosig_q   <= 1'b0;
            ovfl_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            fcount_q  <= fcount_d;
            valid_q   <= valid_d;
            nosig_q   <= nosig_d;
            ovfl_q    <= ovfl_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        fcount_d   = fcount_q;
        valid_d    = valid_q;
        nosig_d    = nosig_q;
        ovfl_d     = ovfl_q;
        overrun_d  = 1'b0;
        load       = 1'b0;
        last_cycle = (gate_q == GATE_LAST);

        // Count including this cycle's edge; the counter sticks at full scale.
        cnt_inc = cnt_q;
        sat_inc = sat_q;
        if (edge_pulse) begin
            if (cnt_q == CNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                cnt_inc = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_MEASURE;
                    gate_d  = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (last_cycle) begin
                    // Result is taken even if enable just fell; enable only
                    // decides whether the next window follows without a gap.
                    load    = 1'b1;
                    gate_d  = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = enable ? ST_MEASURE : ST_IDLE;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                    gate_d  = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end else begin
                    gate_d = gate_q + 32'd1;
                    cnt_d  = cnt_inc;
                    sat_d  = sat_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (valid_q && freq_ready) begin
            valid_d = 1'b0;
        end

        if (load) begin
            fcount_d  = cnt_inc;
            nosig_d   = (cnt_inc == '0);
            ovfl_d    = sat_inc;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~freq_ready;
        end
    end

    assign freq_count = fcount_q;
    assign freq_valid = valid_q;
    assign no_signal  = nosig_q;
    assign overflow   = ovfl_q;
    assign overrun    = overrun_q;

endmodule
